// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - Pong engine shared types: game state encoding and PS/2 set-2 key codes.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_J     = 8'h3B;
  localparam logic [7:0] KEY_L     = 8'h4B;

endpackage

// File: rtl/pong_paddle.sv
// rtl/pong_paddle.sv - Saturating one-step left/right move of a paddle centre between its limits.
module pong_paddle #(
  parameter int POS_W   = 10,
  parameter int MIN_POS = 43,
  parameter int MAX_POS = 596,
  parameter int STEP    = 8
) (
  input  logic [POS_W-1:0] pos,
  input  logic             move_left,
  input  logic             move_right,
  output logic [POS_W-1:0] next_pos
);

  localparam logic [POS_W-1:0] MIN_P  = POS_W'(MIN_POS);
  localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);

  always_comb begin
    next_pos = pos;
    if (move_left)
      next_pos = (pos < MIN_P + STEP_P) ? MIN_P : pos - STEP_P;
    else if (move_right)
      next_pos = (pos > MAX_P - STEP_P) ? MAX_P : pos + STEP_P;
  end

endmodule

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - Pong engine: game FSM, ball, paddles and scores, stepped once per frame_tick.
// Define PONG_AI_EN to build the computer opponent for paddle 2.
module pong_engine
  import pong_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int POS_W        = 10,
  parameter int BORDER       = 11,
  parameter int PADDLE_W     = 64,
  parameter int PADDLE_Y_OFS = 24,
  parameter int BALL_SIZE    = 8,
  parameter int DIV_INIT     = 5,
  parameter int WIN_SCORE    = 9,
  parameter int AI_DIV       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  output logic [2:0]       game_state,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic [POS_W-1:0] paddle1_x,
  output logic [POS_W-1:0] paddle2_x,
  output logic [3:0]       score1,
  output logic [3:0]       score2,
  output logic [1:0]       winner,
  output logic             two_player
);

  localparam int PAD_MIN = BORDER + PADDLE_W / 2;
  localparam int PAD_MAX = H_RES - 1 - BORDER - PADDLE_W / 2;

  localparam logic [POS_W-1:0] STEP    = POS_W'(BALL_SIZE);
  localparam logic [POS_W-1:0] X_MIN   = POS_W'(BORDER + BALL_SIZE / 2);
  localparam logic [POS_W-1:0] X_MAX   = POS_W'(H_RES - 1 - BORDER - BALL_SIZE / 2);
  localparam logic [POS_W-1:0] Y_TOP   = POS_W'(BORDER);
  localparam logic [POS_W-1:0] Y_BOT   = POS_W'(V_RES - 1 - BORDER);
  localparam logic [POS_W-1:0] HIT_TOP = POS_W'(PADDLE_Y_OFS + BALL_SIZE);
  localparam logic [POS_W-1:0] HIT_BOT = POS_W'(V_RES - PADDLE_Y_OFS - BALL_SIZE);
  localparam logic [POS_W-1:0] HALF_PW = POS_W'(PADDLE_W / 2);
  localparam logic [POS_W-1:0] X_MID   = POS_W'(H_RES / 2);
  localparam logic [POS_W-1:0] Y_MID   = POS_W'(V_RES / 2);
  localparam logic [5:0]       DIV0    = 6'(DIV_INIT);
  localparam logic [3:0]       WIN     = 4'(WIN_SCORE);

  state_t           state;
  logic [7:0]       pend;
  logic [7:0]       key;
  logic [5:0]       div;
  logic [5:0]       spd_cnt;
  logic             dx_neg;
  logic             dy_neg;
  logic             in_play;
  logic             p2_left;
  logic             p2_right;
  logic [POS_W-1:0] p1_next;
  logic [POS_W-1:0] p2_next;
  logic [POS_W-1:0] d1;
  logic [POS_W-1:0] d2;
  logic [POS_W-1:0] bx_n;
  logic [POS_W-1:0] by_n;
  logic             dx_n;
  logic             dy_n;
  logic [5:0]       div_n;
  logic             miss_top;
  logic             miss_bot;

  // A key arriving on the tick itself wins over the latched one.
  assign key        = key_valid ? key_code : pend;
  assign in_play    = (state == ST_PLAY);
  assign game_state = state;

`ifdef PONG_AI_EN
  logic       two_player_r;
  logic [5:0] ai_cnt;
  logic       ai_step;

  assign ai_step    = !two_player_r && (ai_cnt == 6'(AI_DIV));
  assign two_player = two_player_r;
  assign p2_left    = in_play && (two_player_r ? (key == KEY_J) : (ai_step && ball_x < paddle2_x));
  assign p2_right   = in_play && (two_player_r ? (key == KEY_L) : (ai_step && ball_x > paddle2_x));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      two_player_r <= 1'b0;
      ai_cnt       <= '0;
    end else if (frame_tick) begin
      if (state == ST_SELECT && key == KEY_1)
        two_player_r <= 1'b0;
      else if (state == ST_SELECT && key == KEY_2)
        two_player_r <= 1'b1;
      if (state == ST_IDLE)
        ai_cnt <= '0;
      else if (in_play)
        ai_cnt <= (ai_cnt == 6'(AI_DIV)) ? 6'd0 : ai_cnt + 6'd1;
    end
  end
`else
  assign two_player = 1'b1;
  assign p2_left    = in_play && (key == KEY_J);
  assign p2_right   = in_play && (key == KEY_L);
`endif

  pong_paddle #(.POS_W(POS_W), .MIN_POS(PAD_MIN), .MAX_POS(PAD_MAX), .STEP(BALL_SIZE)) u_paddle1 (
    .pos        (paddle1_x),
    .move_left  (in_play && key == KEY_A),
    .move_right (in_play && key == KEY_D),
    .next_pos   (p1_next)
  );

  pong_paddle #(.POS_W(POS_W), .MIN_POS(PAD_MIN), .MAX_POS(PAD_MAX), .STEP(BALL_SIZE)) u_paddle2 (
    .pos        (paddle2_x),
    .move_left  (p2_left),
    .move_right (p2_right),
    .next_pos   (p2_next)
  );

  // Hit tests see the paddles after this frame's key move.
  assign d1 = (ball_x >= p1_next) ? ball_x - p1_next : p1_next - ball_x;
  assign d2 = (ball_x >= p2_next) ? ball_x - p2_next : p2_next - ball_x;

  always_comb begin
    bx_n     = ball_x;
    by_n     = ball_y;
    dx_n     = dx_neg;
    dy_n     = dy_neg;
    div_n    = div;
    miss_top = 1'b0;
    miss_bot = 1'b0;
    if (!dx_neg) begin
      if (ball_x >= X_MAX - STEP) begin
        bx_n = X_MAX;
        dx_n = 1'b1;
      end else
        bx_n = ball_x + STEP;
    end else begin
      if (ball_x <= X_MIN + STEP) begin
        bx_n = X_MIN;
        dx_n = 1'b0;
      end else
        bx_n = ball_x - STEP;
    end
    if (!dy_neg) begin
      if (d1 <= HALF_PW && ball_y >= HIT_BOT) begin
        dy_n  = 1'b1;
        by_n  = ball_y - STEP;
        div_n = (div > 6'd1) ? div - 6'd1 : 6'd1;
      end else if (ball_y + STEP > Y_BOT)
        miss_bot = 1'b1;
      else
        by_n = ball_y + STEP;
    end else begin
      if (d2 <= HALF_PW && ball_y <= HIT_TOP) begin
        dy_n  = 1'b0;
        by_n  = ball_y + STEP;
        div_n = (div > 6'd1) ? div - 6'd1 : 6'd1;
      end else if (ball_y < Y_TOP + STEP)
        miss_top = 1'b1;
      else
        by_n = ball_y - STEP;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pend      <= '0;
      ball_x    <= X_MID;
      ball_y    <= Y_MID;
      paddle1_x <= X_MID;
      paddle2_x <= X_MID;
      score1    <= '0;
      score2    <= '0;
      winner    <= '0;
      div       <= DIV0;
      spd_cnt   <= '0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
    end else begin
      if (frame_tick)
        pend <= '0;
      else if (key_valid)
        pend <= key_code;

      if (frame_tick) begin
        case (state)
          ST_IDLE: begin
            ball_x    <= X_MID;
            ball_y    <= Y_MID;
            paddle1_x <= X_MID;
            paddle2_x <= X_MID;
            score1    <= '0;
            score2    <= '0;
            winner    <= '0;
            div       <= DIV0;
            spd_cnt   <= '0;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            state     <= ST_SELECT;
          end
          ST_SELECT: begin
            if (key == KEY_SPACE) begin
              dx_neg  <= 1'b0;
              dy_neg  <= 1'b0;
              div     <= DIV0;
              spd_cnt <= '0;
              state   <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            paddle1_x <= p1_next;
            paddle2_x <= p2_next;
            if (key == KEY_SPACE)
              state <= ST_PAUSE;
            else if (key == KEY_ESC)
              state <= ST_IDLE;
            else if (spd_cnt != div)
              spd_cnt <= spd_cnt + 6'd1;
            else begin
              spd_cnt <= '0;
              if (miss_bot || miss_top) begin
                ball_x <= X_MID;
                ball_y <= Y_MID;
                div    <= DIV0;
                dy_neg <= miss_top;
                if (miss_bot) begin
                  score2 <= score2 + 4'd1;
                  if (score2 + 4'd1 == WIN) begin
                    winner <= 2'd2;
                    state  <= ST_OVER;
                  end
                end else begin
                  score1 <= score1 + 4'd1;
                  if (score1 + 4'd1 == WIN) begin
                    winner <= 2'd1;
                    state  <= ST_OVER;
                  end
                end
              end else begin
                ball_x <= bx_n;
                ball_y <= by_n;
                dx_neg <= dx_n;
                dy_neg <= dy_n;
                div    <= div_n;
              end
            end
          end
          ST_PAUSE: begin
            if (key == KEY_SPACE)
              state <= ST_PLAY;
            else if (key == KEY_ESC)
              state <= ST_IDLE;
          end
          ST_OVER: begin
            if (key == KEY_SPACE || key == KEY_ESC)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - Directed self-checking bench for pong_engine (default build or PONG_AI_EN).
module tb_pong_engine;

  logic       clock;
  logic       reset;
  logic       frame_tick;
  logic       key_valid;
  logic [7:0] key_code;
  logic [2:0] game_state;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle1_x;
  logic [9:0] paddle2_x;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic       two_player;

  int tests = 0;
  int fails = 0;

  pong_engine dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .game_state (game_state),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle1_x  (paddle1_x),
    .paddle2_x  (paddle2_x),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .two_player (two_player)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic key(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clock);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic key_tick(input logic [7:0] code);
    key_valid  = 1'b1;
    key_code   = code;
    frame_tick = 1'b1;
    @(posedge clock);
    #1;
    key_valid  = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    frame_tick = 1'b0;
    key_valid  = 1'b0;
    key_code   = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", game_state, 0);
    check("rst_ball_x", ball_x, 320);
    check("rst_ball_y", ball_y, 240);
    check("rst_p1", paddle1_x, 320);
    check("rst_p2", paddle2_x, 320);
    check("rst_score1", score1, 0);
    check("rst_score2", score2, 0);
    check("rst_winner", winner, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    tick();
    tick();
    check("select_state", game_state, 1);

    key(8'h16);
    tick();
`ifdef PONG_AI_EN
    check("two_player_1key", two_player, 0);
`else
    check("two_player_1key", two_player, 1);
`endif

    key(8'h29);
    tick();
    check("play_state", game_state, 2);
    repeat (5) tick();
    check("no_move_5", ball_x, 320);
    tick();
    check("move6_x", ball_x, 328);
    check("move6_y", ball_y, 248);

    key_tick(8'h1C);
    check("same_cycle_A", paddle1_x, 312);

    key(8'h23);
    tick();
    check("d_first", paddle1_x, 320);
    for (int i = 0; i < 39; i++) begin
      key(8'h23);
      tick();
    end
    check("d_saturate", paddle1_x, 596);

    repeat (126) tick();
    check("pre_miss_x", ball_x, 544);
    check("pre_miss_y", ball_y, 464);
    check("pre_miss_score2", score2, 0);
    tick();
    check("miss_score2", score2, 1);
    check("miss_ball_x", ball_x, 320);
    check("miss_ball_y", ball_y, 240);

    key(8'h29);
    tick();
    check("pause_state", game_state, 3);
    repeat (10) tick();
    key(8'h1C);
    tick();
    repeat (9) tick();
    check("pause_ball_x", ball_x, 320);
    check("pause_ball_y", ball_y, 240);
    check("pause_p1", paddle1_x, 596);
    check("pause_still", game_state, 3);

    key(8'h29);
    tick();
    check("resume_state", game_state, 2);
    repeat (1391) tick();
    check("pre_win_state", game_state, 2);
    check("pre_win_score2", score2, 8);
    tick();
    check("over_state", game_state, 4);
    check("over_winner", winner, 2);
    check("over_score2", score2, 9);
    check("over_score1", score1, 0);
    tick();
    check("over_hold", game_state, 4);

    key(8'h76);
    tick();
    check("esc_idle", game_state, 0);
    tick();
    check("idle_select", game_state, 1);
    check("idle_score2", score2, 0);
    check("idle_winner", winner, 0);
    check("idle_p1", paddle1_x, 320);

    key(8'h29);
    tick();
    for (int i = 0; i < 26; i++) begin
      key(8'h23);
      tick();
    end
    repeat (135) tick();
    check("hit_p1", paddle1_x, 528);
    check("pre_hit_x", ball_x, 528);
    check("pre_hit_y", ball_y, 448);
    tick();
    check("hit_x", ball_x, 536);
    check("hit_y", ball_y, 440);
    repeat (4) tick();
    check("hit_div_wait", ball_y, 440);
    tick();
    check("hit_div_move_x", ball_x, 544);
    check("hit_div_move_y", ball_y, 432);
    check("hit_score2", score2, 0);

`ifndef PONG_AI_EN
    check("p2_idle", paddle2_x, 320);
    key(8'h4B);
    tick();
    check("p2_l_key", paddle2_x, 328);
`endif

    reset = 1'b0;
    #2;
    check("midrst_state", game_state, 0);
    check("midrst_ball_y", ball_y, 240);
    check("midrst_p1", paddle1_x, 320);
    @(posedge clock);
    #1;
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
